// File: rtl/divide_by_two.sv
// divide_by_two: registered halving stage, quotient truncated toward zero.
// Each accepted word appears one clock later, qualified by out_valid.
// There is no backpressure, so a new word can be accepted every cycle.
//
// Parameters:
//   N       data width in bits (N >= 2)
//   SIGNED  0 = unsigned operands, 1 = two's-complement operands
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset, clears all state
//   in_valid   data_in carries a word this cycle
//   data_in    dividend, N bits
//   out_valid  data_out holds a freshly computed quotient
//   data_out   registered quotient data_in / 2, N bits
module divide_by_two #(
    parameter int unsigned N      = 8,
    parameter int unsigned SIGNED = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] data_in,
    output logic         out_valid,
    output logic [N-1:0] data_out
);

    localparam int unsigned W = N;

    logic [W-1:0] bias_c;
    logic [W-1:0] sum_c;
    logic [W-1:0] quotient_c;

    // Negative signed operands are biased by +1 before the arithmetic shift,
    // so the shift rounds toward zero instead of toward minus infinity.
    // The bias cannot overflow, because a negative value plus one is <= 0.
    always_comb begin
        bias_c = '0;
        if (SIGNED != 0) begin
            bias_c = W'(data_in[W-1]);
        end
        sum_c = data_in + bias_c;
    end

    // Halve the biased operand.
    // The signed shift sits in its own branch so it keeps its signed context.
    always_comb begin
        quotient_c = sum_c >> 1;
        if (SIGNED != 0) begin
            quotient_c = W'($signed(sum_c) >>> 1);
        end
    end

    // Output register.
    // data_out holds its value on idle cycles; out_valid pulses for one cycle per word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= quotient_c;
            end
        end
    end

endmodule

// File: tb/tb_divide_by_two.sv
// Bench for divide_by_two.
// An unsigned instance and a signed instance share the same stimulus.
// Expected quotients come from integer division and go into a scoreboard queue.
module tb_divide_by_two;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] data_in;
    logic       out_valid_u;
    logic       out_valid_s;
    logic [7:0] data_out_u;
    logic [7:0] data_out_s;

    divide_by_two #(.N(8), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
        .out_valid(out_valid_u), .data_out(data_out_u)
    );

    divide_by_two #(.N(8), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
        .out_valid(out_valid_s), .data_out(data_out_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [7:0]  eu;
        logic [7:0]  es;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc         = 0;
    logic [7:0]  held_u      = 8'h00;
    logic [7:0]  held_s      = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] half_u(input logic [7:0] d);
        int unsigned v;
        v = int'(d) / 2;
        return 8'(v);
    endfunction

    function automatic logic [7:0] half_s(input logic [7:0] d);
        int s;
        s = int'($signed(d));
        s = s / 2;
        return 8'(s);
    endfunction

    // Drive one cycle of stimulus on the falling edge.
    // A valid word is scoreboarded for the capture edge that follows.
    task automatic drive(input logic v, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        data_in  = d;
        if (v) begin
            e.due = cyc + 1;
            e.eu  = half_u(d);
            e.es  = half_s(d);
            sb.push_back(e);
        end
    endtask

    task automatic flush();
        sb.delete();
        held_u = 8'h00;
        held_s = 8'h00;
    endtask

    // Monitor: samples 1 time unit after every rising edge while rst is low.
    // On a cycle with a word due, it checks out_valid and both quotients.
    // On any other cycle, out_valid must be low and data_out must hold its value.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst) begin
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    check("valid_u", 32'(out_valid_u), 32'd1);
                    check("valid_s", 32'(out_valid_s), 32'd1);
                    check("data_u", 32'(data_out_u), 32'(e.eu));
                    check("data_s", 32'(data_out_s), 32'(e.es));
                    held_u = e.eu;
                    held_s = e.es;
                end else begin
                    check("idle_valid_u", 32'(out_valid_u), 32'd0);
                    check("idle_valid_s", 32'(out_valid_s), 32'd0);
                    check("hold_u", 32'(data_out_u), 32'(held_u));
                    check("hold_s", 32'(data_out_s), 32'(held_s));
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        data_in  = 8'h00;
        #1;
        check("rst_valid_u", 32'(out_valid_u), 32'd0);
        check("rst_data_u", 32'(data_out_u), 32'd0);
        check("rst_data_s", 32'(data_out_s), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned sequence, back to back.
        drive(1'b1, 8'd0);
        drive(1'b1, 8'd6);
        drive(1'b1, 8'd15);
        // Unsigned extremes.
        drive(1'b1, 8'd255);
        drive(1'b1, 8'd1);
        drive(1'b1, 8'd128);
        // Signed corner values.
        drive(1'b1, 8'hF9);
        drive(1'b1, 8'hFF);
        drive(1'b1, 8'h80);
        drive(1'b1, 8'h7F);
        // Hold: the last result is 3, then data_in toggles while in_valid is low.
        drive(1'b1, 8'd6);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'($urandom));

        // Asynchronous reset with data_out at 0x55.
        drive(1'b1, 8'hAA);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_data_u", 32'(data_out_u), 32'h55);
        #2;
        rst = 1'b1;
        flush();
        #1;
        check("async_rst_data_u", 32'(data_out_u), 32'd0);
        check("async_rst_valid_u", 32'(out_valid_u), 32'd0);
        check("async_rst_data_s", 32'(data_out_s), 32'd0);
        check("async_rst_valid_s", 32'(out_valid_s), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset asserted in the same cycle as a presented word: that word is discarded.
        drive(1'b1, 8'd40);
        drive(1'b1, 8'd50);
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 8'd60;
        rst      = 1'b1;
        flush();
        @(posedge clk);
        #1;
        check("midrst_valid_u", 32'(out_valid_u), 32'd0);
        check("midrst_valid_s", 32'(out_valid_s), 32'd0);
        check("midrst_data_u", 32'(data_out_u), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        drive(1'b1, 8'd100);
        drive(1'b1, 8'h9C);

        // Random traffic with gaps.
        for (int i = 0; i < 40; i++) drive(1'($urandom_range(0, 1)), 8'($urandom));
        for (int i = 0; i < 3; i++) drive(1'b0, 8'($urandom));
        @(posedge clk);
        #2;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
